// File: rtl/safecrack_pkg.sv
// Shared constants, arbiter state type and helpers for the safe controller input front end.
package safecrack_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  localparam int unsigned CLK_FREQ                = 50_000_000;

  localparam logic BTN_IDLE     = 1'b1;
  localparam logic CONFIRM_IDLE = 1'b0;

  typedef enum logic {P_IDLE, P_HELD} press_state_t;

  function automatic logic [2:0] count_falls(input logic [3:0] fall);
    return 3'(fall[0]) + 3'(fall[1]) + 3'(fall[2]) + 3'(fall[3]);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchroniser, stability counter and clean level register.
module debounce_cell
  import safecrack_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
  parameter logic        IDLE_LEVEL      = BTN_IDLE
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_clean,
  output logic o_fall
);

  logic             r_s1;
  logic             r_s2;
  logic             r_clean;
  logic [CNT_W-1:0] r_cnt;
  logic             w_expire;

  assign w_expire = (r_s2 != r_clean) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1    <= IDLE_LEVEL;
      r_s2    <= IDLE_LEVEL;
      r_clean <= IDLE_LEVEL;
      r_cnt   <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_clean) begin
        r_cnt <= '0;
      end else if (w_expire) begin
        r_clean <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_clean = r_clean;
  // Combinational so the arbiter registers its pulse on the same edge the clean level falls.
  assign o_fall  = w_expire & r_clean;

endmodule

// File: rtl/safecrack_input_conditioner.sv
// Debounces KEY0-3 and SW1 and arbitrates button presses into a one-hot pulse or a reject strobe.
module safecrack_input_conditioner
  import safecrack_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [3:0] i_btn_n_raw,
  input  logic       i_confirm_raw,
  output logic [3:0] o_btn_n_clean,
  output logic       o_confirm_clean,
  output logic [3:0] o_press_pulse,
  output logic       o_press_reject
);

  logic [3:0]   w_btn_clean;
  logic [3:0]   w_btn_fall;
  logic         w_confirm_clean;
  logic         w_unused_confirm_fall;
  logic         w_all_up;
  logic [2:0]   w_nfall;
  press_state_t r_state;
  logic [3:0]   r_pulse;
  logic         r_reject;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .IDLE_LEVEL     (BTN_IDLE)
    ) u_btn (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (i_btn_n_raw[g]),
      .o_clean(w_btn_clean[g]),
      .o_fall (w_btn_fall[g])
    );
  end

  debounce_cell #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W),
    .IDLE_LEVEL     (CONFIRM_IDLE)
  ) u_confirm (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_raw  (i_confirm_raw),
    .o_clean(w_confirm_clean),
    .o_fall (w_unused_confirm_fall)
  );

  assign w_all_up = &w_btn_clean;
  assign w_nfall  = count_falls(w_btn_fall);

  // Once every button reads released, falls are judged as fresh presses even before leaving P_HELD.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= P_IDLE;
      r_pulse  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_pulse  <= '0;
      r_reject <= 1'b0;
      if (r_state == P_IDLE || w_all_up) begin
        if (w_nfall == 3'd1) begin
          r_pulse <= w_btn_fall;
          r_state <= P_HELD;
        end else if (w_nfall > 3'd1) begin
          r_reject <= 1'b1;
          r_state  <= P_HELD;
        end else begin
          r_state <= P_IDLE;
        end
      end else begin
        r_reject <= |w_btn_fall;
        r_state  <= P_HELD;
      end
    end
  end

  assign o_btn_n_clean   = w_btn_clean;
  assign o_confirm_clean = w_confirm_clean;
  assign o_press_pulse   = r_pulse;
  assign o_press_reject  = r_reject;

endmodule

// File: tb/tb_safecrack_input_conditioner.sv
// Bench for safecrack_input_conditioner: window-based reference model plus directed press scenarios.
module tb_safecrack_input_conditioner;

  localparam int unsigned DB = 4;
  localparam logic [4:0] IDLE5 = 5'b01111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_n_raw;
  logic       confirm_raw;
  logic [3:0] btn_n_clean;
  logic       confirm_clean;
  logic [3:0] press_pulse;
  logic       press_reject;

  int n_checks = 0;
  int n_errors = 0;
  int n_pulse  = 0;
  int n_rej    = 0;
  logic [3:0] last_pulse = 4'h0;
  int p0;
  int r0;

  always #5 clk = ~clk;

  safecrack_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          ($clog2(DB))
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_btn_n_raw    (btn_n_raw),
    .i_confirm_raw  (confirm_raw),
    .o_btn_n_clean  (btn_n_clean),
    .o_confirm_clean(confirm_clean),
    .o_press_pulse  (press_pulse),
    .o_press_reject (press_reject)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a level flips once the synchronised input has differed from it
  // on each of the last DB edges; presses judged from the set of falling buttons.
  logic [4:0] m_s1, m_s2, m_clean, m_next;
  logic [4:0] m_hist [DB];
  logic       m_held;
  logic [3:0] m_pulse, m_falls;
  logic       m_reject;
  logic       m_stable;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = IDLE5; m_s2 = IDLE5; m_clean = IDLE5;
        for (int k = 0; k < DB; k++) m_hist[k] = IDLE5;
        m_held = 1'b0; m_pulse = 4'h0; m_reject = 1'b0;
      end else begin
        for (int k = DB - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = m_s2;
        m_next = m_clean;
        for (int c = 0; c < 5; c++) begin
          m_stable = 1'b1;
          for (int k = 0; k < DB; k++) if (m_hist[k][c] == m_clean[c]) m_stable = 1'b0;
          if (m_stable) m_next[c] = ~m_clean[c];
        end
        m_falls  = m_clean[3:0] & ~m_next[3:0];
        m_pulse  = 4'h0;
        m_reject = 1'b0;
        if (!m_held || m_clean[3:0] == 4'hF) begin
          if ($countones(m_falls) == 1) begin
            m_pulse = m_falls; m_held = 1'b1;
          end else if ($countones(m_falls) > 1) begin
            m_reject = 1'b1; m_held = 1'b1;
          end else begin
            m_held = 1'b0;
          end
        end else begin
          m_reject = |m_falls;
        end
        m_s2 = m_s1;
        m_s1 = {confirm_raw, btn_n_raw};
        m_clean = m_next;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("model_btn_clean", int'(btn_n_clean), int'(m_clean[3:0]));
        check("model_confirm", int'(confirm_clean), int'(m_clean[4]));
        check("model_pulse", int'(press_pulse), int'(m_pulse));
        check("model_reject", int'(press_reject), int'(m_reject));
        check("pulse_reject_excl", int'((|press_pulse) & press_reject), 0);
        if (press_pulse != 4'h0) begin
          n_pulse++;
          last_pulse = press_pulse;
        end
        if (press_reject) n_rej++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; btn_n_raw = 4'hF; confirm_raw = 1'b0;
    tick(3);
    check("reset_btn_clean", int'(btn_n_clean), 4'hF);
    check("reset_confirm", int'(confirm_clean), 0);
    check("reset_pulse", int'(press_pulse), 0);
    check("reset_reject", int'(press_reject), 0);
    rst = 1'b0;
    tick(2);

    // KEY2 press and release
    btn_n_raw = 4'b1011;
    tick(5);
    check("key2_before_edge5", int'(btn_n_clean), 4'hF);
    tick(1);
    check("key2_clean_edge5", int'(btn_n_clean), 4'hB);
    check("key2_pulse", int'(press_pulse), 4'b0100);
    tick(1);
    check("key2_pulse_one_cycle", int'(press_pulse), 0);
    tick(5);
    p0 = n_pulse;
    btn_n_raw = 4'hF;
    tick(5);
    check("key2_release_before", int'(btn_n_clean), 4'hB);
    tick(1);
    check("key2_release_edge5", int'(btn_n_clean), 4'hF);
    tick(6);
    check("key2_release_no_pulse", n_pulse - p0, 0);

    // KEY0 bounce never gets through
    p0 = n_pulse; r0 = n_rej;
    repeat (4) begin
      btn_n_raw = 4'b1110; tick(3);
      btn_n_raw = 4'hF;    tick(1);
    end
    tick(8);
    check("bounce_clean", int'(btn_n_clean), 4'hF);
    check("bounce_no_pulse", n_pulse - p0, 0);
    check("bounce_no_reject", n_rej - r0, 0);

    // KEY1+KEY3 together rejected, then KEY0 accepted
    p0 = n_pulse; r0 = n_rej;
    btn_n_raw = 4'b0101;
    tick(6);
    check("multi_clean", int'(btn_n_clean), 4'b0101);
    check("multi_no_pulse", n_pulse - p0, 0);
    check("multi_reject", n_rej - r0, 1);
    btn_n_raw = 4'hF;
    tick(10);
    p0 = n_pulse;
    btn_n_raw = 4'b1110;
    tick(10);
    check("after_multi_pulse_count", n_pulse - p0, 1);
    check("after_multi_pulse_val", int'(last_pulse), 4'b0001);
    btn_n_raw = 4'hF;
    tick(10);

    // KEY0 held, KEY1 pressed later
    p0 = n_pulse; r0 = n_rej;
    btn_n_raw = 4'b1110;
    tick(10);
    btn_n_raw = 4'b1100;
    tick(10);
    check("held_pulse_count", n_pulse - p0, 1);
    check("held_pulse_val", int'(last_pulse), 4'b0001);
    check("held_reject_count", n_rej - r0, 1);
    btn_n_raw = 4'hF;
    tick(12);
    check("held_release_pulses", n_pulse - p0, 1);
    check("held_release_clean", int'(btn_n_clean), 4'hF);

    // Confirm debounce and reset mid-count
    confirm_raw = 1'b1; tick(2);
    confirm_raw = 1'b0; tick(10);
    check("confirm_short", int'(confirm_clean), 0);
    confirm_raw = 1'b1;
    tick(5);
    check("confirm_before_edge5", int'(confirm_clean), 0);
    tick(1);
    check("confirm_edge5", int'(confirm_clean), 1);
    tick(4);
    confirm_raw = 1'b0;
    tick(10);
    check("confirm_released", int'(confirm_clean), 0);
    confirm_raw = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("confirm_rst_level", int'(confirm_clean), 0);
    tick(1);
    rst = 1'b0;
    tick(5);
    check("confirm_after_rst_before", int'(confirm_clean), 0);
    tick(1);
    check("confirm_after_rst_edge5", int'(confirm_clean), 1);

    // Reset with all buttons down; KEY3 held through release
    confirm_raw = 1'b0;
    btn_n_raw = 4'h0;
    tick(2);
    rst = 1'b1;
    #1;
    check("midrst_btn_clean", int'(btn_n_clean), 4'hF);
    check("midrst_confirm", int'(confirm_clean), 0);
    check("midrst_pulse", int'(press_pulse), 0);
    check("midrst_reject", int'(press_reject), 0);
    btn_n_raw = 4'b0111;
    tick(2);
    rst = 1'b0;
    tick(5);
    check("held_through_rst_before", int'(btn_n_clean), 4'hF);
    tick(1);
    check("held_through_rst_clean", int'(btn_n_clean), 4'b0111);
    check("held_through_rst_pulse", int'(press_pulse), 4'b1000);
    btn_n_raw = 4'hF;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/safecrack_input_conditioner.md
# safecrack_input_conditioner

Front-end conditioner for the safe controller's operator inputs. Synchronises and debounces the four KEY buttons (active-low) and the SW1 programming switch. Drives clean levels into the controller's `btn_n`/`confirm` inputs. Also produces an arbitrated one-hot press pulse, so a multi-button press is rejected rather than decoded by priority.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz): consecutive stable cycles required before a clean level changes. Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`: debounce counter width.
- `clk` input 1: system clock, 50 MHz.
- `rst` input 1: reset, asynchronous, active-high.
- `btn_n_raw` input 4: raw KEY0-3, active-low, asynchronous.
- `confirm_raw` input 1: raw SW1, active-high, asynchronous.
- `btn_n_clean` output 4: debounced KEY levels, active-low.
- `confirm_clean` output 1: debounced SW1 level.
- `press_pulse` output 4: one-hot, one cycle, marks an accepted single-button press.
- `press_reject` output 1: one cycle, marks a rejected multi-button press.

## Operation
- Per channel (5 total): 2-flop synchroniser `s1`→`s2`, clean register, counter `cnt`.
  - Idle level: 1 for buttons, 0 for confirm.
  - `s2 == clean`: `cnt` ← 0.
  - `s2 != clean` and `cnt == DEBOUNCE_CYCLES-1`: clean ← `s2`, `cnt` ← 0. Otherwise `cnt` ← `cnt+1`.
  - Any return of `s2` to the clean value restarts the count. Glitches shorter than `DEBOUNCE_CYCLES` never reach the output.
- A fall of a channel is `clean` going 1→0 on a button channel. It is seen on the edge where `clean` updates.
- Press arbiter FSM, states `P_IDLE` and `P_HELD`. It acts on clean button levels only; confirm is not arbitrated.
  - `P_IDLE`, exactly one channel falls and all other clean buttons are 1: assert `press_pulse` one-hot for that button; go to `P_HELD`.
  - `P_IDLE`, two or more channels fall on the same edge: `press_pulse` = 0; assert `press_reject`; go to `P_HELD`.
  - `P_HELD`: no pulses are issued. A new fall while a button is held asserts `press_reject` once per fall. Stay in `P_HELD` until `btn_n_clean == 4'hF`, then go to `P_IDLE`.
  - In `P_IDLE` with all buttons already 1, no pulse is issued.
- Reset behaviour:
  - All synchronisers and clean registers go to their idle levels; counters go to 0; the FSM goes to `P_IDLE`.
  - A reset during a count discards that count.
  - A button held through reset release is debounced from scratch. It produces a normal accepted press after `DEBOUNCE_CYCLES+2` edges.

## Timing
- Reset values: `btn_n_clean` = 4'hF, `confirm_clean` = 0, `press_pulse` = 0, `press_reject` = 0.
- Clean latency: raw changes before edge 0 and stays stable. The clean output changes on edge `DEBOUNCE_CYCLES+1` (counting from edge 0), i.e. it is valid after `DEBOUNCE_CYCLES+2` rising edges.
- `press_pulse` and `press_reject` are registered. They are high for exactly the one cycle after the edge on which `clean` falls.
- Releases produce no pulse. Minimum gap between accepted presses is release latency plus press latency, i.e. `2·(DEBOUNCE_CYCLES+2)` cycles.
- `press_pulse` and `press_reject` are never high in the same cycle.

## Structure
- `safecrack_pkg` holds:
  - `DEBOUNCE_CYCLES` default
  - idle-level constants `BTN_IDLE = 1'b1`, `CONFIRM_IDLE = 1'b0`
  - arbiter state enum `press_state_t {P_IDLE, P_HELD}`
  - `CLK_FREQ = 50_000_000`
- Sub-module `debounce_cell`, parameters `DEBOUNCE_CYCLES` and `IDLE_LEVEL`:
  - contains the synchroniser, counter and clean register;
  - outputs `clean` and a one-cycle `fall` strobe;
  - instantiated 4× for buttons and 1× for confirm.
- The top level contains the arbiter FSM and the output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset asserted mid-simulation with `btn_n_raw` = 4'h0 → outputs are immediately 4'hF, 0, 0, 0. After release, the FSM is in `P_IDLE`.
- `btn_n_raw[2]` 1→0, held 12 cycles → `btn_n_clean[2]` falls on edge 5. `press_pulse` = 4'b0100 for exactly one cycle. Release → clean rises after 6 edges with no pulse.
- `btn_n_raw[0]` bounces (low 3 cycles, high 1 cycle, ×4), then rests high → `btn_n_clean` stays 4'hF and both pulse outputs stay 0 throughout.
- `btn_n_raw[1]` and `btn_n_raw[3]` fall on the same cycle → `press_reject` = 1 for one cycle, `press_pulse` = 0. Release both, then press KEY0 → `press_pulse` = 4'b0001.
- KEY0 held, and KEY1 pressed 10 cycles later → one `press_pulse` of 4'b0001, then one `press_reject`. No further pulses until all four buttons are released.
- `confirm_raw` high for 2 cycles → `confirm_clean` stays 0. `confirm_raw` high for 10 cycles → `confirm_clean` rises on edge 5. Reset asserted at count 2, then released with `confirm_raw` still high → `confirm_clean` is 0 and rises again 6 edges after reset release.
